// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I funct3 codes and error codes.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_ILLEGAL  = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } lsu_err_t;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store replication/byte enables, load extraction/extension,
// and legality/alignment checks for one RV32I memory access.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic        write,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // funct3[1:0] is the access size for both loads and stores
   always_comb begin
      store_data = wdata;
      be         = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            store_data = {4{wdata[7:0]}};
            be         = 4'b0001 << addr_lo;
         end
         2'b01: begin
            store_data = {2{wdata[15:0]}};
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'b00:   sel_byte = rdata[7:0];
         2'b01:   sel_byte = rdata[15:8];
         2'b10:   sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_data = {24'd0, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_data = {16'd0, sel_half};
         F3_W:    load_data = rdata;
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
      if (write)
         illegal = funct3[2] || (funct3[1:0] == 2'b11);
      else
         illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: captures an ALU-side request, runs a valid/ready
// memory transaction and returns extended load data or an error code.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid,
   input  logic        lsu_write,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic [1:0]  lsu_err_code,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata
);

   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   lsu_state_t  state;
   logic        cap_write;
   logic [2:0]  cap_funct3;
   logic [1:0]  cap_addr_lo;
   logic [15:0] tcount;
   logic [15:0] tcount_next;

   logic        al_write;
   logic [2:0]  al_funct3;
   logic [1:0]  al_addr_lo;
   logic [31:0] al_store_data;
   logic [3:0]  al_be;
   logic [31:0] al_load_data;
   logic        al_misaligned;
   logic        al_illegal;

   // The aligner checks the live request while idle and the captured one afterwards
   assign al_write    = (state == IDLE) ? lsu_write       : cap_write;
   assign al_funct3   = (state == IDLE) ? lsu_funct3      : cap_funct3;
   assign al_addr_lo  = (state == IDLE) ? lsu_addr[1:0]   : cap_addr_lo;
   assign tcount_next = tcount + 16'd1;
   assign lsu_busy    = (state != IDLE);

   lsu_data_align u_align (
      .write      (al_write),
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .wdata      (lsu_wdata),
      .rdata      (mem_resp_rdata),
      .store_data (al_store_data),
      .be         (al_be),
      .load_data  (al_load_data),
      .misaligned (al_misaligned),
      .illegal    (al_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         tcount        <= '0;
         cap_write     <= 1'b0;
         cap_funct3    <= 3'd0;
         cap_addr_lo   <= 2'd0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= 32'd0;
         mem_req_wdata <= 32'd0;
         mem_req_be    <= 4'd0;
         lsu_done      <= 1'b0;
         lsu_err       <= 1'b0;
         lsu_err_code  <= ERR_NONE;
         lsu_rdata     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (lsu_valid) begin
                  cap_write   <= lsu_write;
                  cap_funct3  <= lsu_funct3;
                  cap_addr_lo <= lsu_addr[1:0];
                  if (al_illegal) begin
                     state        <= DONE;
                     lsu_done     <= 1'b1;
                     lsu_err      <= 1'b1;
                     lsu_err_code <= ERR_ILLEGAL;
                  end else if (al_misaligned) begin
                     state        <= DONE;
                     lsu_done     <= 1'b1;
                     lsu_err      <= 1'b1;
                     lsu_err_code <= ERR_MISALIGN;
                  end else begin
                     state         <= REQ;
                     tcount        <= '0;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= lsu_write;
                     mem_req_addr  <= {lsu_addr[31:2], 2'b00};
                     mem_req_wdata <= lsu_write ? al_store_data : 32'd0;
                     mem_req_be    <= al_be;
                  end
               end
            end
            // Timeout takes priority over a handshake landing on the same cycle
            REQ, RESP: begin
               tcount <= tcount_next;
               if (tcount_next == TIMEOUT_LIM) begin
                  state         <= DONE;
                  mem_req_valid <= 1'b0;
                  mem_req_we    <= 1'b0;
                  mem_req_addr  <= 32'd0;
                  mem_req_wdata <= 32'd0;
                  mem_req_be    <= 4'd0;
                  lsu_done      <= 1'b1;
                  lsu_err       <= 1'b1;
                  lsu_err_code  <= ERR_TIMEOUT;
               end else if (state == REQ) begin
                  if (mem_req_ready) begin
                     state         <= RESP;
                     mem_req_valid <= 1'b0;
                     mem_req_we    <= 1'b0;
                     mem_req_addr  <= 32'd0;
                     mem_req_wdata <= 32'd0;
                     mem_req_be    <= 4'd0;
                  end
               end else if (mem_resp_valid) begin
                  state     <= DONE;
                  lsu_done  <= 1'b1;
                  lsu_rdata <= cap_write ? 32'd0 : al_load_data;
               end
            end
            default: begin
               state        <= IDLE;
               lsu_done     <= 1'b0;
               lsu_err      <= 1'b0;
               lsu_err_code <= ERR_NONE;
               lsu_rdata    <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven memory side and TIMEOUT_CYCLES=4.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lsu_valid = 1'b0;
   logic        lsu_write = 1'b0;
   logic [2:0]  lsu_funct3 = 3'd0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wdata = 32'd0;
   logic        lsu_busy;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic [1:0]  lsu_err_code;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_rdata = 32'd0;

   int checks = 0;
   int errors = 0;

   logic        obs_done;
   int          obs_cycles;
   int          obs_req_cycles;
   int          obs_unstable;
   logic        obs_busy;
   logic        obs_we;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_be;
   logic [31:0] obs_rdata;
   logic        obs_err;
   logic [1:0]  obs_code;
   int          stray;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .lsu_valid      (lsu_valid),
      .lsu_write      (lsu_write),
      .lsu_funct3     (lsu_funct3),
      .lsu_addr       (lsu_addr),
      .lsu_wdata      (lsu_wdata),
      .lsu_busy       (lsu_busy),
      .lsu_done       (lsu_done),
      .lsu_rdata      (lsu_rdata),
      .lsu_err        (lsu_err),
      .lsu_err_code   (lsu_err_code),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_be     (mem_req_be),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic write, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      lsu_valid  = 1'b1;
      lsu_write  = write;
      lsu_funct3 = f3;
      lsu_addr   = addr;
      lsu_wdata  = wdata;
   endtask

   // Issues one request and watches up to 20 cycles for the done pulse
   task automatic runTxn(input logic write, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(write, f3, addr, wdata);
      obs_done = 1'b0; obs_cycles = 0; obs_req_cycles = 0; obs_unstable = 0;
      obs_busy = 1'b0; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_be = '0;
      obs_rdata = '0; obs_err = 1'b0; obs_code = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            lsu_valid = 1'b0;
            obs_busy  = lsu_busy;
         end
         if (mem_req_valid) begin
            if (obs_req_cycles == 0) begin
               obs_we = mem_req_we; obs_addr = mem_req_addr;
               obs_wdata = mem_req_wdata; obs_be = mem_req_be;
            end else if (mem_req_we !== obs_we || mem_req_addr !== obs_addr ||
                         mem_req_wdata !== obs_wdata || mem_req_be !== obs_be) begin
               obs_unstable++;
            end
            obs_req_cycles++;
         end
         if (lsu_done) begin
            obs_done = 1'b1; obs_cycles = n;
            obs_rdata = lsu_rdata; obs_err = lsu_err; obs_code = lsu_err_code;
            break;
         end
      end
      checkOutput("done_seen", 32'(obs_done), 32'd1);
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"},  32'(lsu_busy), 32'd0);
      checkOutput({tag, "_done"},  32'(lsu_done), 32'd0);
      checkOutput({tag, "_reqv"},  32'(mem_req_valid), 32'd0);
      checkOutput({tag, "_addr"},  mem_req_addr, 32'd0);
      checkOutput({tag, "_be"},    32'(mem_req_be), 32'd0);
      checkOutput({tag, "_rdata"}, lsu_rdata, 32'd0);
      checkOutput({tag, "_err"},   32'(lsu_err), 32'd0);
      checkOutput({tag, "_code"},  32'(lsu_err_code), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      checkIdleZero("reset");
      rst = 1'b1;

      // Zero-wait store word
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
      runTxn(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF);
      checkOutput("sw_latency", 32'(obs_cycles), 32'd3);
      checkOutput("sw_busy", 32'(obs_busy), 32'd1);
      checkOutput("sw_we", 32'(obs_we), 32'd1);
      checkOutput("sw_addr", obs_addr, 32'h100);
      checkOutput("sw_be", 32'(obs_be), 32'hF);
      checkOutput("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
      checkOutput("sw_err", 32'(obs_err), 32'd0);
      checkOutput("sw_rdata", obs_rdata, 32'd0);
      @(negedge clk);
      checkOutput("sw_done_once", 32'(lsu_done), 32'd0);
      checkOutput("sw_idle", 32'(lsu_busy), 32'd0);

      // Byte loads at the top lane
      mem_resp_rdata = 32'h80FF_0000;
      runTxn(1'b0, F3_B, 32'h103, 32'd0);
      checkOutput("lb_be", 32'(obs_be), 32'h8);
      checkOutput("lb_addr", obs_addr, 32'h100);
      checkOutput("lb_we", 32'(obs_we), 32'd0);
      checkOutput("lb_rdata", obs_rdata, 32'hFFFF_FF80);
      runTxn(1'b0, F3_BU, 32'h103, 32'd0);
      checkOutput("lbu_rdata", obs_rdata, 32'h0000_0080);

      // Halfword loads and stores, plus a byte store in lane 1
      mem_resp_rdata = 32'h8001_1234;
      runTxn(1'b0, F3_H, 32'h102, 32'd0);
      checkOutput("lh_be", 32'(obs_be), 32'hC);
      checkOutput("lh_rdata", obs_rdata, 32'hFFFF_8001);
      runTxn(1'b0, F3_HU, 32'h100, 32'd0);
      checkOutput("lhu_be", 32'(obs_be), 32'h3);
      checkOutput("lhu_rdata", obs_rdata, 32'h0000_1234);
      runTxn(1'b1, F3_H, 32'h102, 32'h0000_ABCD);
      checkOutput("sh_be", 32'(obs_be), 32'hC);
      checkOutput("sh_wdata", obs_wdata, 32'hABCD_ABCD);
      checkOutput("sh_rdata", obs_rdata, 32'd0);
      runTxn(1'b1, F3_B, 32'h201, 32'h0000_005A);
      checkOutput("sb_be", 32'(obs_be), 32'h2);
      checkOutput("sb_addr", obs_addr, 32'h200);
      checkOutput("sb_wdata", obs_wdata, 32'h5A5A_5A5A);

      // Errors raised at accept, no memory access
      runTxn(1'b0, F3_W, 32'h101, 32'd0);
      checkOutput("lw_mis_latency", 32'(obs_cycles), 32'd1);
      checkOutput("lw_mis_noreq", 32'(obs_req_cycles), 32'd0);
      checkOutput("lw_mis_err", 32'(obs_err), 32'd1);
      checkOutput("lw_mis_code", 32'(obs_code), 32'd1);
      runTxn(1'b0, F3_H, 32'h103, 32'd0);
      checkOutput("lh_mis_code", 32'(obs_code), 32'd1);
      runTxn(1'b0, 3'b011, 32'h100, 32'd0);
      checkOutput("ld_ill_noreq", 32'(obs_req_cycles), 32'd0);
      checkOutput("ld_ill_code", 32'(obs_code), 32'd2);
      runTxn(1'b1, 3'b100, 32'h100, 32'd0);
      checkOutput("st_ill_code", 32'(obs_code), 32'd2);
      runTxn(1'b1, 3'b011, 32'h103, 32'd0);
      checkOutput("ill_over_mis_code", 32'(obs_code), 32'd2);

      // Timeout with memory never ready
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      runTxn(1'b0, F3_W, 32'h300, 32'd0);
      checkOutput("to_req_cycles", 32'(obs_req_cycles), 32'd4);
      checkOutput("to_stable", 32'(obs_unstable), 32'd0);
      checkOutput("to_latency", 32'(obs_cycles), 32'd5);
      checkOutput("to_err", 32'(obs_err), 32'd1);
      checkOutput("to_code", 32'(obs_code), 32'd3);
      checkOutput("to_rdata", obs_rdata, 32'd0);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (lsu_done || lsu_busy || mem_req_valid) stray++;
      end
      checkOutput("stray_resp_ignored", 32'(stray), 32'd0);
      mem_resp_valid = 1'b0;

      // Reset while waiting in RESP, then a clean load
      mem_req_ready = 1'b1;
      applyStimulus(1'b0, F3_W, 32'h200, 32'd0);
      @(posedge clk); @(negedge clk);
      lsu_valid = 1'b0;
      checkOutput("rst_in_req", 32'(mem_req_valid), 32'd1);
      @(posedge clk); @(negedge clk);
      checkOutput("rst_in_resp_busy", 32'(lsu_busy), 32'd1);
      checkOutput("rst_in_resp_reqv", 32'(mem_req_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      checkIdleZero("midrst");
      rst = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
      runTxn(1'b0, F3_W, 32'h204, 32'd0);
      checkOutput("post_rst_latency", 32'(obs_cycles), 32'd3);
      checkOutput("post_rst_addr", obs_addr, 32'h204);
      checkOutput("post_rst_rdata", obs_rdata, 32'h1234_5678);
      checkOutput("post_rst_err", 32'(obs_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
